xfifo_sc: RTL and testbench

Synchronous soft FIFO with one clock for both the read and write ports, built from registers or inferred block RAM with no vendor primitives. It is the default (non-hardware-primitive) implementation behind the common-clock fifo wrapper used throughout the MPEG-2 decoder. It provides standard-read (non-first-word-fall-through) semantics, Xilinx-style status flags, handshake flags and programmable thresholds. Read or write attempts that the FIFO rejects never corrupt its contents.

---
 rtl/xfifo_sc.sv | 106 ++++++++++
 tb/tb_xfifo_sc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/xfifo_sc.sv
// Single-clock soft FIFO with standard (registered) read port, Xilinx-style flags and handshakes.
// Latency: write-to-flags 1 edge, read 1 cycle (rd_en edge -> dout/valid), write-to-dout 2 cycles.
// Backpressure: writes rejected while full (overflow pulse), reads rejected while empty (underflow pulse).
module xfifo_sc #(
    parameter int unsigned dta_width   = 8,
    parameter int unsigned addr_width  = 8,
    parameter int unsigned prog_thresh = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [dta_width-1:0] din,
    input  logic                 wr_en,
    output logic                 full,
    output logic                 wr_ack,
    output logic                 overflow,
    output logic                 prog_full,
    output logic [dta_width-1:0] dout,
    input  logic                 rd_en,
    output logic                 empty,
    output logic                 valid,
    output logic                 underflow,
    output logic                 prog_empty
);

    localparam int unsigned DEPTH = 2 ** addr_width;
    localparam int unsigned PF_INT = DEPTH - prog_thresh;

    // Flag thresholds sized to the occupancy counter.
    localparam logic [addr_width:0] FULL_LVL = DEPTH[addr_width:0];
    localparam logic [addr_width:0] PE_LVL   = prog_thresh[addr_width:0];
    localparam logic [addr_width:0] PF_LVL   = PF_INT[addr_width:0];

    logic [dta_width-1:0]  mem [DEPTH];
    logic [addr_width-1:0] wp;
    logic [addr_width-1:0] rp;
    logic [addr_width:0]   count;
    logic                  wr_ok;
    logic                  rd_ok;

    // Acceptance is decided only by the flags at this edge; a same-cycle read never frees room for a write.
    always_comb begin
        wr_ok = wr_en & ~full;
        rd_ok = rd_en & ~empty;
    end

    // Status flags are pure decodes of the occupancy register.
    always_comb begin
        empty      = (count == '0);
        full       = (count == FULL_LVL);
        prog_empty = (count <= PE_LVL);
        prog_full  = (count >= PF_LVL);
    end

    // Storage array: no reset, written only on accepted writes so rejected requests cannot corrupt it.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (rd_ok) begin
                rp <= rp + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered read port: dout holds its last value unless a read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (rd_ok) begin
            dout <= mem[rp];
        end
    end

    // One-cycle handshake pulses describing the previous cycle's requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            valid     <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_ok;
            overflow  <= wr_en & full;
            valid     <= rd_ok;
            underflow <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_xfifo_sc.sv
// Directed bench for xfifo_sc with DEPTH=16, prog_thresh=2.
module tb_xfifo_sc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       full, wr_ack, overflow, prog_full;
    logic [7:0] dout;
    logic       empty, valid, underflow, prog_empty;

    int checks = 0;
    int errors = 0;
    logic [7:0] q[$];
    logic [7:0] exp_d;

    xfifo_sc #(.dta_width(8), .addr_width(4), .prog_thresh(2)) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
        .wr_ack(wr_ack), .overflow(overflow), .prog_full(prog_full),
        .dout(dout), .rd_en(rd_en), .empty(empty), .valid(valid),
        .underflow(underflow), .prog_empty(prog_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " empty"}, 32'(empty), 32'd1);
        chk({tag, " full"}, 32'(full), 32'd0);
        chk({tag, " prog_empty"}, 32'(prog_empty), 32'd1);
        chk({tag, " prog_full"}, 32'(prog_full), 32'd0);
        chk({tag, " dout"}, 32'(dout), 32'd0);
        chk({tag, " valid"}, 32'(valid), 32'd0);
        chk({tag, " underflow"}, 32'(underflow), 32'd0);
        chk({tag, " wr_ack"}, 32'(wr_ack), 32'd0);
        chk({tag, " overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        // Reset and idle
        #1;
        chk_idle("reset");
        step(); step();
        rst = 1'b0;
        step();
        chk_idle("idle");

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            din   = 8'(i);
            q.push_back(8'(i));
            step();
            chk($sformatf("fill%0d wr_ack", i), 32'(wr_ack), 32'd1);
            chk($sformatf("fill%0d prog_empty", i), 32'(prog_empty), 32'((i + 1) <= 2));
            chk($sformatf("fill%0d prog_full", i), 32'(prog_full), 32'((i + 1) >= 14));
            chk($sformatf("fill%0d full", i), 32'(full), 32'((i + 1) == 16));
            chk($sformatf("fill%0d empty", i), 32'(empty), 32'd0);
        end
        // 17th write rejected
        din = 8'hAA;
        step();
        chk("wr17 overflow", 32'(overflow), 32'd1);
        chk("wr17 wr_ack", 32'(wr_ack), 32'd0);
        chk("wr17 full", 32'(full), 32'd1);
        wr_en = 1'b0;
        step();
        chk("wr17 overflow pulse", 32'(overflow), 32'd0);
        chk("wr17 still full", 32'(full), 32'd1);

        // Drain
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            exp_d = q.pop_front();
            step();
            chk($sformatf("drain%0d valid", i), 32'(valid), 32'd1);
            chk($sformatf("drain%0d dout", i), 32'(dout), 32'(exp_d));
            chk($sformatf("drain%0d empty", i), 32'(empty), 32'(i == 15));
            chk($sformatf("drain%0d full", i), 32'(full), 32'd0);
        end
        // 17th read rejected
        step();
        chk("rd17 underflow", 32'(underflow), 32'd1);
        chk("rd17 valid", 32'(valid), 32'd0);
        chk("rd17 dout hold", 32'(dout), 32'h0F);

        // Simultaneous read+write while empty: write only, no write-through
        wr_en = 1'b1;
        din   = 8'h55;
        q.push_back(8'h55);
        step();
        chk("rw_empty underflow", 32'(underflow), 32'd1);
        chk("rw_empty wr_ack", 32'(wr_ack), 32'd1);
        chk("rw_empty valid", 32'(valid), 32'd0);
        chk("rw_empty dout", 32'(dout), 32'h0F);
        chk("rw_empty empty", 32'(empty), 32'd0);
        rd_en = 1'b0;

        // Bring count to 5
        for (int i = 0; i < 4; i++) begin
            din = 8'h56 + 8'(i);
            q.push_back(din);
            step();
        end
        chk("cnt5 prog_empty", 32'(prog_empty), 32'd0);

        // 20 cycles of concurrent read and write at count 5, wrapping pointers
        rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            din   = 8'h60 + 8'(i);
            exp_d = q.pop_front();
            q.push_back(din);
            step();
            chk($sformatf("stream%0d valid", i), 32'(valid), 32'd1);
            chk($sformatf("stream%0d dout", i), 32'(dout), 32'(exp_d));
            chk($sformatf("stream%0d wr_ack", i), 32'(wr_ack), 32'd1);
            chk($sformatf("stream%0d prog_empty", i), 32'(prog_empty), 32'd0);
            chk($sformatf("stream%0d full", i), 32'(full), 32'd0);
        end
        rd_en = 1'b0;

        // Fill to full (5 + 11)
        for (int i = 0; i < 11; i++) begin
            din = 8'h80 + 8'(i);
            q.push_back(din);
            step();
        end
        chk("refill full", 32'(full), 32'd1);

        // Simultaneous read+write while full: read only
        rd_en = 1'b1;
        din   = 8'hC0;
        exp_d = q.pop_front();
        step();
        chk("rw_full overflow", 32'(overflow), 32'd1);
        chk("rw_full wr_ack", 32'(wr_ack), 32'd0);
        chk("rw_full valid", 32'(valid), 32'd1);
        chk("rw_full dout", 32'(dout), 32'(exp_d));
        chk("rw_full full", 32'(full), 32'd0);
        chk("rw_full prog_full", 32'(prog_full), 32'd1);
        wr_en = 1'b0;

        // Read down to 7 entries, checking order
        for (int i = 0; i < 8; i++) begin
            exp_d = q.pop_front();
            step();
            chk($sformatf("down%0d dout", i), 32'(dout), 32'(exp_d));
        end
        rd_en = 1'b0;
        step();
        chk("hold7 empty", 32'(empty), 32'd0);
        chk("hold7 prog_empty", 32'(prog_empty), 32'd0);

        // Asynchronous reset between edges
        #3;
        rst = 1'b1;
        #1;
        chk_idle("async_rst");
        step();
        rst = 1'b0;
        rd_en = 1'b1;
        step();
        chk("post_rst underflow", 32'(underflow), 32'd1);
        chk("post_rst valid", 32'(valid), 32'd0);
        chk("post_rst empty", 32'(empty), 32'd1);
        chk("post_rst dout", 32'(dout), 32'd0);
        rd_en = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
